adder_2stage: RTL and testbench
===============================

# adder_2stage

Two-stage pipelined unsigned adder. It adds two `WIDTH`-bit operands into a `WIDTH+1`-bit sum that includes the carry-out. Stage 1 adds the lower half and registers the carry. Stage 2 adds the upper half plus that carry. The block is a drop-in datapath element for paths where a full-width single-cycle carry chain misses timing.

## Interface
- `WIDTH`, default 32: operand width. Must be even and ≥ 2; half width `HALF = WIDTH/2`.
- `clock`  in  1: rising-edge clock, single domain.
- `reset`  in  1: asynchronous, active-low reset.
- `in_1`  in  WIDTH: operand A, unsigned.
- `in_2`  in  WIDTH: operand B, unsigned.
- `out_sum`  out  WIDTH+1: registered sum A+B; MSB is the carry-out.

## Operation
- `out_sum` always equals the exact unsigned sum `in_1 + in_2`. There is no wrap-around, because the extra MSB absorbs the carry.
- Stage 1 registers, on each rising edge:
  - `lo_sum = in_1[HALF-1:0] + in_2[HALF-1:0]`, `HALF` bits.
  - `c_mid`, the carry-out of `lo_sum`.
  - `in_1[WIDTH-1:HALF]` and `in_2[WIDTH-1:HALF]`.
- Stage 2 registers `out_sum = {hi_a + hi_b + c_mid, lo_sum}`, where the upper part is `HALF+1` bits.
- There is no handshake and no valid signal. A new operand pair is accepted every cycle (throughput 1/cycle). Constant inputs yield a constant output after the latency.
- Reset while `reset` = 0:
  - All pipeline registers clear immediately (asynchronously) to 0.
  - `out_sum` reads 0 and stays 0 until reset is released.
  - Results in flight are discarded.
- Reset release: the first valid sum appears 2 rising edges after the first post-release edge that samples inputs.

## Timing
- Inputs sampled at rising edge N.
- Stage 1 holds the partial result after edge N.
- `out_sum` updates after edge N+1, so latency is 2 clock edges.
- No combinational path from inputs to `out_sum`.
- Reset value of `out_sum`: all zeros.
- Critical path is one `HALF+1`-bit add per stage.

## Configuration
- Macro `ADDER_2STAGE_IN_REG_EN`.
- Defined:
  - An input register stage captures `in_1`/`in_2` before stage 1.
  - Latency becomes 3 edges.
  - The input registers also reset asynchronously to 0.
- Undefined: stage 1 adds the inputs directly, with latency 2 as specified above.
- Arithmetic results are identical in both builds; only latency differs.

## Structure
- Package `adder_2stage_pkg` holds:
  - `DEFAULT_WIDTH` = 32.
  - A function or localparam helper for `HALF`.
  - The latency constants `LAT_BASE` = 2 and `LAT_IN_REG` = 3, for use by benches.
- Sub-module `adder_half`:
  - Parameterised `HALF`-bit adder with carry-in and carry-out, purely combinational.
  - Instantiated once per stage; stage 1 has carry-in tied to 0, stage 2 takes `c_mid`.
- Top level owns all registers and the reset logic.

## Test plan
- **Basic add:** with reset released, apply 3827 + 9273, then hold. `out_sum` = 13100 two edges later and stays 13100 while the inputs are held.
- **Back-to-back streaming:** apply 0+9253, 1+0, 200+100 on consecutive edges. Outputs are 9253, 1, 300 on consecutive edges, each 2 edges after its inputs.
- **Mid carry and carry-out:**
  - 0x0FFFFFFF + 0xFFFFFFEF gives 0x10FFFFFEE.
  - 0xFFFFFFF1 + 0x0FFFFFEF gives 0x10FFFFFE0.
  - In both cases the lower-half carry propagates and the MSB is set.
- **Upper overflow without mid carry:**
  - 0xFFFF3841 + 0xFFFFB3AE gives 0x1FFFEEBEF.
  - 0xFFFF0000 + 0xFFFF0000 gives 0x1FFFE0000.
- **Reset mid-stream:**
  - Drive nonzero operands every cycle, then pull `reset` low between edges. `out_sum` goes to 0 immediately, without waiting for a clock edge.
  - After release, `out_sum` stays 0 until 2 edges after the first sampled pair, then shows the correct sums.
- **Build with `ADDER_2STAGE_IN_REG_EN`:** 13442 + 10042 gives 23484 exactly 3 edges after it is applied.

Source files
------------

// File: rtl/adder_2stage_pkg.sv
// Shared constants for the two-stage pipelined adder: default width, half-width helper
// and the pipeline latencies seen by benches in each build.
package adder_2stage_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int LAT_BASE      = 2;
  localparam int LAT_IN_REG    = 3;

  function automatic int half_w(input int width);
    return width / 2;
  endfunction

endpackage

// File: rtl/adder_half.sv
// Combinational HALF-bit adder with carry-in and carry-out; one instance per pipeline stage.
module adder_half #(
  parameter int HALF = 16
) (
  input  logic [HALF-1:0] a,
  input  logic [HALF-1:0] b,
  input  logic            cin,
  output logic [HALF-1:0] sum,
  output logic            cout
);

  logic [HALF:0] full;

  assign full = {1'b0, a} + {1'b0, b} + {{HALF{1'b0}}, cin};
  assign sum  = full[HALF-1:0];
  assign cout = full[HALF];

endmodule

// File: rtl/adder_2stage.sv
// Two-stage pipelined unsigned adder: lower half plus carry in stage 1, upper half in stage 2.
// Optional input register stage selected by `define ADDER_2STAGE_IN_REG_EN (latency 3 instead of 2).
module adder_2stage
  import adder_2stage_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  output logic [WIDTH:0]   out_sum
);

  localparam int HALF = half_w(WIDTH);

  logic [WIDTH-1:0] a_p0;
  logic [WIDTH-1:0] b_p0;

  // Stage 0: operands presented to the lower-half adder
`ifdef ADDER_2STAGE_IN_REG_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      a_p0 <= '0;
      b_p0 <= '0;
    end else begin
      a_p0 <= in_1;
      b_p0 <= in_2;
    end
  end
`else
  assign a_p0 = in_1;
  assign b_p0 = in_2;
`endif

  logic [HALF-1:0] lo_sum_c;
  logic            c_mid_c;

  adder_half #(.HALF(HALF)) u_lo (
    .a    (a_p0[HALF-1:0]),
    .b    (b_p0[HALF-1:0]),
    .cin  (1'b0),
    .sum  (lo_sum_c),
    .cout (c_mid_c)
  );

  logic [HALF-1:0] lo_sum_p1;
  logic            c_mid_p1;
  logic [HALF-1:0] hi_a_p1;
  logic [HALF-1:0] hi_b_p1;

  // Stage 1: lower-half sum, mid carry and untouched upper halves
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lo_sum_p1 <= '0;
      c_mid_p1  <= 1'b0;
      hi_a_p1   <= '0;
      hi_b_p1   <= '0;
    end else begin
      lo_sum_p1 <= lo_sum_c;
      c_mid_p1  <= c_mid_c;
      hi_a_p1   <= a_p0[WIDTH-1:HALF];
      hi_b_p1   <= b_p0[WIDTH-1:HALF];
    end
  end

  logic [HALF-1:0] hi_sum_c;
  logic            c_out_c;

  adder_half #(.HALF(HALF)) u_hi (
    .a    (hi_a_p1),
    .b    (hi_b_p1),
    .cin  (c_mid_p1),
    .sum  (hi_sum_c),
    .cout (c_out_c)
  );

  // Stage 2: full-width result with carry-out as MSB
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_sum <= '0;
    end else begin
      out_sum <= {c_out_c, hi_sum_c, lo_sum_p1};
    end
  end

endmodule

// File: tb/tb_adder_2stage.sv
// Self-checking bench for adder_2stage: directed vectors, random streaming and async reset,
// compared against an arithmetic reference delayed by the build's latency.
module tb_adder_2stage;
  import adder_2stage_pkg::*;

  localparam int W = DEFAULT_WIDTH;
`ifdef ADDER_2STAGE_IN_REG_EN
  localparam int LAT = LAT_IN_REG;
`else
  localparam int LAT = LAT_BASE;
`endif

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] in_1  = '0;
  logic [W-1:0] in_2  = '0;
  logic [W:0]   out_sum;

  int checks = 0;
  int errors = 0;

  // Exact sums of every operand pair sampled since the last reset release
  logic [W:0] sums_q[$];

  always #5 clock = ~clock;

  adder_2stage #(.WIDTH(W)) dut (
    .clock   (clock),
    .reset   (reset),
    .in_1    (in_1),
    .in_2    (in_2),
    .out_sum (out_sum)
  );

  function automatic logic [W:0] model_out();
    if (sums_q.size() >= LAT) return sums_q[sums_q.size() - LAT];
    return '0;
  endfunction

  task automatic check(input string tag, input logic [W:0] exp);
    checks++;
    assert (out_sum === exp)
    else begin
      errors++;
      $error("FAIL %s: out_sum=0x%h expected=0x%h", tag, out_sum, exp);
    end
  endtask

  task automatic step(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    in_1 = a;
    in_2 = b;
    #1 check({tag, "_hold"}, model_out());
    @(posedge clock);
    sums_q.push_back({1'b0, a} + {1'b0, b});
    #1 check(tag, model_out());
  endtask

  task automatic hold_check(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W:0] exp, input string tag);
    repeat (LAT) step(a, b, tag);
    check({tag, "_const"}, exp);
  endtask

  initial begin
    // Held in reset: output must read zero regardless of inputs
    in_1 = 32'hDEAD_BEEF;
    in_2 = 32'h1234_5678;
    #1 check("reset_init", '0);
    repeat (3) @(posedge clock);
    #1 check("reset_held", '0);
    reset = 1'b1;

    hold_check(32'd3827, 32'd9273, 33'd13100, "basic");
    step(32'd3827, 32'd9273, "basic_stay");
    check("basic_stay_const", 33'd13100);

    step(32'd0,   32'd9253, "stream0");
    step(32'd1,   32'd0,    "stream1");
    step(32'd200, 32'd100,  "stream2");
    repeat (LAT) step(32'd0, 32'd0, "stream_flush");

    hold_check(32'h0FFF_FFFF, 32'hFFFF_FFEF, 33'h1_0FFF_FFEE, "midcarry_a");
    hold_check(32'hFFFF_FFF1, 32'h0FFF_FFEF, 33'h1_0FFF_FFE0, "midcarry_b");
    hold_check(32'hFFFF_3841, 32'hFFFF_B3AE, 33'h1_FFFE_EBEF, "upper_ovf_a");
    hold_check(32'hFFFF_0000, 32'hFFFF_0000, 33'h1_FFFE_0000, "upper_ovf_b");
    hold_check(32'hFFFF_FFFF, 32'hFFFF_FFFF, 33'h1_FFFF_FFFE, "all_ones");
    hold_check(32'd13442,     32'd10042,     33'd23484,       "inreg_vec");

    // Exact latency: a fresh pair appears after LAT edges, not one edge sooner
    step(32'd0, 32'd0, "lat_clear");
    repeat (LAT) step(32'd0, 32'd0, "lat_zero");
    step(32'd13442, 32'd10042, "lat_apply");
    for (int i = 1; i < LAT; i++) begin
      step(32'd0, 32'd0, "lat_wait");
      if (i < LAT - 1) check("lat_not_early", '0);
    end
    check("lat_exact", 33'd23484);

    for (int i = 0; i < 200; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = $urandom;
      rb = $urandom;
      case (i % 8)
        0: ra[W/2-1:0] = '1;
        1: rb[W-1:W/2] = '1;
        default: ;
      endcase
      step(ra, rb, "random");
    end

    // Reset asserted between edges with data in flight
    for (int i = 0; i < 5; i++) step($urandom | 32'h1, $urandom | 32'h1, "pre_reset");
    #2 reset = 1'b0;
    #1 check("reset_async", '0);
    sums_q.delete();
    in_1 = 32'hFFFF_FFFF;
    in_2 = 32'hFFFF_FFFF;
    repeat (2) @(posedge clock);
    #1 check("reset_low_edges", '0);
    reset = 1'b1;

    for (int i = 0; i < 20; i++) step($urandom, $urandom, "post_reset");
    hold_check(32'd3827, 32'd9273, 33'd13100, "post_reset_basic");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
